// File: rtl/gray_count_tracker_pkg.sv
// Shared types and Gray-code helpers for the Gray count tracker.
// Helpers operate on a fixed maximum width; callers zero-extend and truncate.
package gray_pkg;

    localparam int ERR_CNT_W  = 8;
    localparam int GRAY_MAX_W = 32;

    typedef enum logic {
        INIT,
        RUN
    } trk_state_e;

    // Each binary bit is the XOR of all Gray bits at or above it; zero upper bits are transparent.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/gray_count_tracker_if.sv
// Signal bundle between local logic (master) and the Gray count tracker (slave).
interface gray_count_tracker_if #(
    parameter int WIDTH = 4,
    parameter int POS_W = 16
);
    import gray_pkg::*;

    logic [WIDTH-1:0]     gray_in;
    logic                 clr;
    logic [WIDTH-1:0]     bin_out;
    logic                 valid;
    logic                 step_up;
    logic                 step_dn;
    logic                 err;
    logic [POS_W-1:0]     pos;
    logic [ERR_CNT_W-1:0] err_cnt;

    modport master (
        output gray_in, clr,
        input  bin_out, valid, step_up, step_dn, err, pos, err_cnt
    );

    modport slave (
        input  gray_in, clr,
        output bin_out, valid, step_up, step_dn, err, pos, err_cnt
    );

endinterface

// File: rtl/gray_count_tracker_sync_ff.sv
// Multi-stage flop synchroniser for a bus whose bits change one at a time (Gray code).
module sync_ff #(
    parameter int W      = 4,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] sync_q [STAGES];

    // NOTE: these are ordinary flops, so every stage is reset; a RAM-style array would not be.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/gray_count_tracker.sv
// Receives an asynchronous Gray count, decodes it and tracks +1/-1 steps into a position
// accumulator, counting illegal transitions. All outputs are registered.
module gray_count_tracker
    import gray_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int POS_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input logic                 clk,
    input logic                 rst_n,
    gray_count_tracker_if.slave bus
);

    localparam int FILL_W = $clog2(SYNC_STAGES + 1);

    logic [WIDTH-1:0]     g_cur;
    logic [WIDTH-1:0]     b_cur, b_prev, b_inc, b_dec, diff;
    trk_state_e           state_q, state_d;
    logic [FILL_W-1:0]    fill_q, fill_d;
    logic [WIDTH-1:0]     g_prev_q, g_prev_d;
    logic [WIDTH-1:0]     bin_out_q, bin_out_d;
    logic                 valid_q, valid_d;
    logic                 step_up_q, step_up_d;
    logic                 step_dn_q, step_dn_d;
    logic                 err_q, err_d;
    logic [POS_W-1:0]     pos_q, pos_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    sync_ff #(.W(WIDTH), .STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (bus.gray_in),
        .q_o   (g_cur)
    );

    assign b_cur  = WIDTH'(gray2bin(GRAY_MAX_W'(g_cur)));
    assign b_prev = WIDTH'(gray2bin(GRAY_MAX_W'(g_prev_q)));
    assign b_inc  = b_prev + 1'b1;
    assign b_dec  = b_prev - 1'b1;
    assign diff   = g_cur ^ g_prev_q;

    // NOTE: every variable gets a default first so no path through the block infers a latch.
    always_comb begin
        state_d   = state_q;
        fill_d    = fill_q;
        g_prev_d  = g_prev_q;
        bin_out_d = bin_out_q;
        valid_d   = valid_q;
        step_up_d = 1'b0;
        step_dn_d = 1'b0;
        err_d     = 1'b0;
        pos_d     = pos_q;
        err_cnt_d = err_cnt_q;

        unique case (state_q)
            INIT: begin
                // Wait until the synchroniser holds a real sample before taking the baseline.
                if (fill_q == FILL_W'(SYNC_STAGES)) begin
                    g_prev_d  = g_cur;
                    bin_out_d = b_cur;
                    valid_d   = 1'b1;
                    state_d   = RUN;
                end else begin
                    fill_d = fill_q + 1'b1;
                end
            end
            RUN: begin
                if (diff != '0) begin
                    g_prev_d  = g_cur;
                    bin_out_d = b_cur;
                    if ($onehot(diff) && (b_cur == b_inc)) begin
                        step_up_d = 1'b1;
                        pos_d     = pos_q + 1'b1;
                    end else if ($onehot(diff) && (b_cur == b_dec)) begin
                        step_dn_d = 1'b1;
                        pos_d     = pos_q - 1'b1;
                    end else begin
                        err_d = 1'b1;
                        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = INIT;
        endcase

        if (bus.clr) begin
            pos_d     = '0;
            err_cnt_d = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= INIT;
            fill_q    <= '0;
            g_prev_q  <= '0;
            bin_out_q <= '0;
            valid_q   <= 1'b0;
            step_up_q <= 1'b0;
            step_dn_q <= 1'b0;
            err_q     <= 1'b0;
            pos_q     <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            fill_q    <= fill_d;
            g_prev_q  <= g_prev_d;
            bin_out_q <= bin_out_d;
            valid_q   <= valid_d;
            step_up_q <= step_up_d;
            step_dn_q <= step_dn_d;
            err_q     <= err_d;
            pos_q     <= pos_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus.bin_out = bin_out_q;
    assign bus.valid   = valid_q;
    assign bus.step_up = step_up_q;
    assign bus.step_dn = step_dn_q;
    assign bus.err     = err_q;
    assign bus.pos     = pos_q;
    assign bus.err_cnt = err_cnt_q;

endmodule

// File: tb/tb_gray_count_tracker.sv
// Directed bench for gray_count_tracker: each Gray step pushes its expected outcome to a
// scoreboard queue, which is popped and compared when the DUT pulses.
module tb_gray_count_tracker;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    typedef struct packed {
        logic [3:0]  bin;
        logic        up;
        logic        dn;
        logic        er;
        logic [15:0] pos;
        logic [7:0]  ec;
    } exp_t;

    exp_t sb_q[$];

    logic [3:0]  m_g;
    logic [3:0]  m_b;
    logic [15:0] m_pos;
    logic [7:0]  m_ec;

    gray_count_tracker_if #(.WIDTH(4), .POS_W(16)) bus ();

    gray_count_tracker #(.WIDTH(4), .POS_W(16), .SYNC_STAGES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    // Binary bit i is the parity of Gray bits i and above.
    function automatic logic [3:0] tb_g2b(input logic [3:0] g);
        logic [3:0] b;
        for (int i = 0; i < 4; i++) b[i] = ^(g >> i);
        return b;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("check %s differs", tag);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".bin_out"}, 32'(bus.bin_out), 0);
        check({tag, ".valid"},   32'(bus.valid),   0);
        check({tag, ".step_up"}, 32'(bus.step_up), 0);
        check({tag, ".step_dn"}, 32'(bus.step_dn), 0);
        check({tag, ".err"},     32'(bus.err),     0);
        check({tag, ".pos"},     32'(bus.pos),     0);
        check({tag, ".err_cnt"}, 32'(bus.err_cnt), 0);
    endtask

    // Drive one Gray value, predict its outcome, wait (bounded) for the pulse, then compare.
    task automatic step(input string tag, input logic [3:0] g, input logic do_clr);
        exp_t       e;
        exp_t       got;
        logic [3:0] bn;
        logic [3:0] d;
        int         k;

        bn = tb_g2b(g);
        d  = g ^ m_g;
        e  = '0;
        e.bin = bn;
        if ($countones(d) == 1 && bn == 4'(m_b + 4'd1)) begin
            e.up  = 1'b1;
            m_pos = m_pos + 16'd1;
        end else if ($countones(d) == 1 && bn == 4'(m_b - 4'd1)) begin
            e.dn  = 1'b1;
            m_pos = m_pos - 16'd1;
        end else begin
            e.er = 1'b1;
            if (m_ec != 8'd255) m_ec = m_ec + 8'd1;
        end
        if (do_clr) begin
            m_pos = '0;
            m_ec  = '0;
        end
        e.pos = m_pos;
        e.ec  = m_ec;
        m_g   = g;
        m_b   = bn;
        sb_q.push_back(e);

        bus.gray_in = g;
        k = 0;
        do begin
            @(negedge clk);
            k++;
            if (k == 2) bus.clr = do_clr;
        end while (!(bus.step_up || bus.step_dn || bus.err) && k < 8);
        bus.clr = 1'b0;

        check({tag, ".latency"}, 32'(k), 3);
        got = sb_q.pop_front();
        check({tag, ".bin_out"}, 32'(bus.bin_out), 32'(got.bin));
        check({tag, ".step_up"}, 32'(bus.step_up), 32'(got.up));
        check({tag, ".step_dn"}, 32'(bus.step_dn), 32'(got.dn));
        check({tag, ".err"},     32'(bus.err),     32'(got.er));
        check({tag, ".pos"},     32'(bus.pos),     32'(got.pos));
        check({tag, ".err_cnt"}, 32'(bus.err_cnt), 32'(got.ec));
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst_n       = 1'b0;
        bus.gray_in = 4'b0000;
        bus.clr     = 1'b0;
        m_g   = 4'b0000;
        m_b   = 4'd0;
        m_pos = '0;
        m_ec  = '0;

        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check("baseline.valid", 32'(bus.valid), (k == 3) ? 1 : 0);
            check("baseline.no_pulse", 32'({bus.step_up, bus.step_dn, bus.err}), 0);
        end
        check("baseline.bin_out", 32'(bus.bin_out), 0);

        // Counting up 0 -> 3
        step("up1", 4'b0001, 1'b0);
        step("up2", 4'b0011, 1'b0);
        step("up3", 4'b0010, 1'b0);

        // Counting down 3 -> 15 through zero
        step("dn1", 4'b0011, 1'b0);
        step("dn2", 4'b0001, 1'b0);
        step("dn3", 4'b0000, 1'b0);
        step("dn4", 4'b1000, 1'b0);

        // Wrap 15 -> 0 is a legal up step
        step("wrap", 4'b0000, 1'b0);

        // Illegal: two-bit change, then single-bit but non-adjacent (2 -> 13)
        step("ill_multi",  4'b0011, 1'b0);
        step("ill_nonadj", 4'b1011, 1'b0);
        for (int i = 0; i < 300; i++) begin
            step("ill_sat", (i % 2 == 0) ? 4'b0000 : 4'b1011, 1'b0);
        end
        check("sat.err_cnt", 32'(bus.err_cnt), 255);

        // Clear coinciding with a step update
        step("pre_clr", 4'b1001, 1'b0);
        step("clr_up",  4'b1000, 1'b1);

        // Climb to pos 5, then async reset mid-count
        step("cnt1", 4'b0000, 1'b0);
        step("cnt2", 4'b0001, 1'b0);
        step("cnt3", 4'b0011, 1'b0);
        step("cnt4", 4'b0010, 1'b0);
        step("cnt5", 4'b0110, 1'b0);
        check("pre_rst.pos", 32'(bus.pos), 5);

        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_rst");
        rst_n = 1'b1;
        m_pos = '0;
        m_ec  = '0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check("rebase.valid", 32'(bus.valid), (k >= 3) ? 1 : 0);
            check("rebase.no_pulse", 32'({bus.step_up, bus.step_dn, bus.err}), 0);
        end
        check("rebase.bin_out", 32'(bus.bin_out), 4);
        check("rebase.pos", 32'(bus.pos), 0);
        step("post_rst", 4'b0111, 1'b0);

        check("sb_empty", 32'(sb_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
